// File: rtl/bcd2_tick_counter_pkg.sv
// bcd2_tick_counter_pkg: shared run-state encoding, 7-segment patterns and digit-enable codes
package bcd2_tick_counter_pkg;

    typedef enum logic {
        ST_STOP = 1'b0,
        ST_RUN  = 1'b1
    } run_state_e;

    localparam logic [6:0] SEG_0     = 7'b1111110;
    localparam logic [6:0] SEG_1     = 7'b0110000;
    localparam logic [6:0] SEG_2     = 7'b1101101;
    localparam logic [6:0] SEG_3     = 7'b1111001;
    localparam logic [6:0] SEG_4     = 7'b0110011;
    localparam logic [6:0] SEG_5     = 7'b1011011;
    localparam logic [6:0] SEG_6     = 7'b1011111;
    localparam logic [6:0] SEG_7     = 7'b1110000;
    localparam logic [6:0] SEG_8     = 7'b1111111;
    localparam logic [6:0] SEG_9     = 7'b1111011;
    localparam logic [6:0] SEG_BLANK = 7'b0000000;

    localparam logic [1:0] COM_ONES = 2'b10;
    localparam logic [1:0] COM_TENS = 2'b01;

endpackage

// File: rtl/bcd2_tick_counter_if.sv
// bcd2_tick_counter_if: tick/control inputs and count/display outputs of the tick counter
interface bcd2_tick_counter_if;

    logic       clk_6hz;
    logic       start_stop;
    logic       clr;
    logic [7:0] bcd;
    logic       carry;
    logic [6:0] seg;
    logic [1:0] com;

    modport master (
        output clk_6hz, start_stop, clr,
        input  bcd, carry, seg, com
    );

    modport slave (
        input  clk_6hz, start_stop, clr,
        output bcd, carry, seg, com
    );

endinterface

// File: rtl/bcd2_tick_counter_seg7_decode.sv
// seg7_decode: combinational BCD digit to active-high a..g segment pattern; codes 10-15 blank
module seg7_decode
    import bcd2_tick_counter_pkg::*;
(
    input  logic [3:0] digit,
    output logic [6:0] seg
);

    // lookup of the standard digit patterns
    always_comb begin
        seg = SEG_BLANK;
        case (digit)
            4'd0: seg = SEG_0;
            4'd1: seg = SEG_1;
            4'd2: seg = SEG_2;
            4'd3: seg = SEG_3;
            4'd4: seg = SEG_4;
            4'd5: seg = SEG_5;
            4'd6: seg = SEG_6;
            4'd7: seg = SEG_7;
            4'd8: seg = SEG_8;
            4'd9: seg = SEG_9;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/bcd2_tick_counter.sv
// bcd2_tick_counter: two-digit BCD tick counter with multiplexed 7-segment display; define LZB_EN for leading-zero blanking
module bcd2_tick_counter
    import bcd2_tick_counter_pkg::*;
#(
    parameter int MOD      = 60,
    parameter int SCAN_DIV = 4
) (
    input logic                clk3,
    input logic                rst,
    bcd2_tick_counter_if.slave bus
);

    localparam logic [7:0]    BCD_MAX   = {4'((MOD - 1) / 10), 4'((MOD - 1) % 10)};
    localparam int            SW        = SCAN_DIV > 1 ? $clog2(SCAN_DIV) : 1;
    localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);

    logic          tick_d;
    logic          inc;
    run_state_e    state;
    run_state_e    state_nxt;
    logic [7:0]    cnt;
    logic          carry_q;
    logic [SW-1:0] scan_cnt;
    logic          sel;
    logic [3:0]    digit;
    logic [6:0]    dec_seg;
    logic          blank;
    logic [6:0]    seg_q;
    logic [1:0]    com_q;

    assign inc   = bus.clk_6hz & ~tick_d;
    assign digit = sel ? cnt[7:4] : cnt[3:0];

`ifdef LZB_EN
    assign blank = sel && cnt[7:4] == 4'd0;
`else
    assign blank = 1'b0;
`endif

    seg7_decode u_dec (
        .digit(digit),
        .seg  (dec_seg)
    );

    // previous tick level for rising-edge detection
    always_ff @(posedge clk3 or posedge rst) begin
        if (rst) tick_d <= 1'b0;
        else     tick_d <= bus.clk_6hz;
    end

    // run state register
    always_ff @(posedge clk3 or posedge rst) begin
        if (rst) state <= ST_STOP;
        else     state <= state_nxt;
    end

    // start_stop toggles between STOP and RUN
    always_comb begin
        state_nxt = state;
        if (bus.start_stop) state_nxt = state == ST_RUN ? ST_STOP : ST_RUN;
    end

    // BCD count with clear priority and wrap carry; the pre-toggle state gates counting
    always_ff @(posedge clk3 or posedge rst) begin
        if (rst) begin
            cnt     <= 8'h00;
            carry_q <= 1'b0;
        end else if (bus.clr) begin
            cnt     <= 8'h00;
            carry_q <= 1'b0;
        end else if (inc && state == ST_RUN) begin
            cnt     <= cnt == BCD_MAX ? 8'h00 :
                       cnt[3:0] == 4'd9 ? {cnt[7:4] + 4'd1, 4'd0} : cnt + 8'd1;
            carry_q <= cnt == BCD_MAX;
        end else begin
            carry_q <= 1'b0;
        end
    end

    // digit scan: each digit stays selected for SCAN_DIV cycles
    always_ff @(posedge clk3 or posedge rst) begin
        if (rst) begin
            scan_cnt <= '0;
            sel      <= 1'b0;
        end else begin
            scan_cnt <= scan_cnt == SCAN_LAST ? '0 : scan_cnt + 1'b1;
            sel      <= scan_cnt == SCAN_LAST ? ~sel : sel;
        end
    end

    // registered display drive for the currently selected digit
    always_ff @(posedge clk3 or posedge rst) begin
        if (rst) begin
            seg_q <= SEG_0;
            com_q <= COM_ONES;
        end else begin
            seg_q <= blank ? SEG_BLANK : dec_seg;
            com_q <= sel ? COM_TENS : COM_ONES;
        end
    end

    assign bus.bcd   = cnt;
    assign bus.carry = carry_q;
    assign bus.seg   = seg_q;
    assign bus.com   = com_q;

endmodule

// File: tb/tb_bcd2_tick_counter.sv
// tb_bcd2_tick_counter: randomized and directed bench against an integer model of the tick counter
module tb_bcd2_tick_counter;

    localparam int MOD      = 60;
    localparam int SCAN_DIV = 4;

    logic clk3 = 1'b0;
    logic rst  = 1'b0;

    bcd2_tick_counter_if bus ();

    bcd2_tick_counter #(.MOD(MOD), .SCAN_DIV(SCAN_DIV)) dut (
        .clk3(clk3),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk3 = ~clk3;

    int n_cmp   = 0;
    int n_bad   = 0;
    int n_carry = 0;

    logic [6:0] segtab [10] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011,
                                7'b1011011, 7'b1011111, 7'b1110000, 7'b1111111, 7'b1111011};

    // model: count as an integer 0..MOD-1, display derived from cycles since reset
    int   m_cnt;
    int   m_k;
    int   m_dcnt;
    logic m_tick_d;
    logic m_run;
    logic m_carry;
    logic m_dsel;
    logic m_inc;

    assign m_inc = bus.clk_6hz && !m_tick_d;

    always @(posedge clk3 or posedge rst) begin
        if (rst) begin
            m_cnt    <= 0;
            m_k      <= 0;
            m_dcnt   <= 0;
            m_tick_d <= 1'b0;
            m_run    <= 1'b0;
            m_carry  <= 1'b0;
            m_dsel   <= 1'b0;
        end else begin
            m_tick_d <= bus.clk_6hz;
            m_run    <= bus.start_stop ? !m_run : m_run;
            m_carry  <= !bus.clr && m_inc && m_run && m_cnt == MOD - 1;
            m_cnt    <= bus.clr ? 0 : (m_inc && m_run) ? (m_cnt + 1) % MOD : m_cnt;
            m_dcnt   <= m_cnt;
            m_dsel   <= ((m_k / SCAN_DIV) % 2) == 1;
            m_k      <= m_k + 1;
        end
    end

    function automatic logic [7:0] exp_bcd(int c);
        return {4'(c / 10), 4'(c % 10)};
    endfunction

    function automatic logic [6:0] exp_seg(int c, logic s);
`ifdef LZB_EN
        if (s && c / 10 == 0) return 7'b0000000;
`endif
        return segtab[s ? c / 10 : c % 10];
    endfunction

    task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic step();
        @(negedge clk3);
        chk("bcd", 32'(bus.bcd), 32'(exp_bcd(m_cnt)));
        chk("carry", 32'(bus.carry), 32'(m_carry));
        chk("com", 32'(bus.com), m_dsel ? 32'h1 : 32'h2);
        chk("seg", 32'(bus.seg), 32'(exp_seg(m_dcnt, m_dsel)));
        if (bus.carry === 1'b1) n_carry++;
        @(posedge clk3);
        #1;
    endtask

    task automatic tick(int hi, int lo);
        bus.clk_6hz = 1'b1;
        repeat (hi) step();
        bus.clk_6hz = 1'b0;
        repeat (lo) step();
    endtask

    task automatic toggle_run();
        bus.start_stop = 1'b1;
        step();
        bus.start_stop = 1'b0;
    endtask

    task automatic clear();
        bus.clr = 1'b1;
        step();
        bus.clr = 1'b0;
    endtask

    task automatic wait_com(logic [1:0] c);
        int i = 0;
        while (bus.com !== c && i < 20) begin
            step();
            i++;
        end
        chk("wait_com", 32'(bus.com), 32'(c));
    endtask

    initial begin
        bus.clk_6hz    = 1'b0;
        bus.start_stop = 1'b0;
        bus.clr        = 1'b0;
        #2 rst = 1'b1;
        step();
        step();
        chk("rst_bcd", 32'(bus.bcd), 32'h00);
        chk("rst_com", 32'(bus.com), 32'h2);
        chk("rst_seg", 32'(bus.seg), 32'h7e);
        rst = 1'b0;
        step();

        toggle_run();
        n_carry = 0;
        repeat (60) tick(1, 1);
        chk("wrap_bcd", 32'(bus.bcd), 32'h00);
        chk("wrap_carries", 32'(n_carry), 32'd1);

        tick(10, 1);
        chk("level_once", 32'(bus.bcd), 32'h01);

        toggle_run();
        repeat (5) tick(1, 1);
        chk("stop_hold", 32'(bus.bcd), 32'h01);
        toggle_run();
        tick(1, 1);
        chk("resume", 32'(bus.bcd), 32'h02);

        clear();
        repeat (59) tick(1, 1);
        chk("at_59", 32'(bus.bcd), 32'h59);
        bus.clr     = 1'b1;
        bus.clk_6hz = 1'b1;
        step();
        bus.clr     = 1'b0;
        bus.clk_6hz = 1'b0;
        chk("clr_tick_bcd", 32'(bus.bcd), 32'h00);
        chk("clr_tick_carry", 32'(bus.carry), 32'h0);
        step();

        repeat (12) tick(1, 1);
        bus.start_stop = 1'b1;
        bus.clk_6hz    = 1'b1;
        step();
        bus.start_stop = 1'b0;
        bus.clk_6hz    = 1'b0;
        chk("ss_tick", 32'(bus.bcd), 32'h13);
        step();
        tick(1, 1);
        chk("ss_then_stop", 32'(bus.bcd), 32'h13);

        rst = 1'b1;
        #1;
        chk("midrst_bcd", 32'(bus.bcd), 32'h00);
        chk("midrst_carry", 32'(bus.carry), 32'h0);
        chk("midrst_com", 32'(bus.com), 32'h2);
        chk("midrst_seg", 32'(bus.seg), 32'h7e);
        step();
        rst = 1'b0;
        tick(1, 1);
        chk("post_rst_stop", 32'(bus.bcd), 32'h00);

        toggle_run();
        repeat (47) tick(1, 1);
        chk("at_47", 32'(bus.bcd), 32'h47);
        step();
        step();
        wait_com(2'b01);
        chk("scan_tens", 32'(bus.seg), 32'(7'b0110011));
        wait_com(2'b10);
        chk("scan_ones", 32'(bus.seg), 32'(7'b1110000));
        repeat (16) step();

        clear();
        repeat (5) tick(1, 1);
        step();
        step();
        wait_com(2'b01);
`ifdef LZB_EN
        chk("lzb_tens", 32'(bus.seg), 32'(7'b0000000));
`else
        chk("lzb_tens", 32'(bus.seg), 32'(7'b1111110));
`endif
        wait_com(2'b10);
        chk("lzb_ones", 32'(bus.seg), 32'(7'b1011011));

        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 2) == 0) bus.clk_6hz = ~bus.clk_6hz;
            bus.start_stop = $urandom_range(0, 40) == 0;
            bus.clr        = $urandom_range(0, 150) == 0;
            if ($urandom_range(0, 900) == 0) rst = 1'b1;
            step();
            rst = 1'b0;
        end
        bus.start_stop = 1'b0;
        bus.clr        = 1'b0;
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
